scfifo: RTL and testbench
=========================

Name: scfifo

Overview:
- Single-clock synchronous FIFO. It is the parametrised successor to the dual-clock dcfifo and is used wherever producer and consumer share one clock.
- Adds the following beyond dcfifo:
  - configurable depth, width and almost-full/almost-empty thresholds
  - fill-level output
  - selectable show-ahead (first-word-fall-through) read mode
  - synchronous clear
  - overflow/underflow error pulses
- Sits between same-clock pipeline stages as an elastic buffer.

Parameters:
DATA_WIDTH, 32, word width in bits
ADDR_WIDTH, 2, log2 of depth; DEPTH = 2**ADDR_WIDTH
AFULL_THRESH, 3, wr_almost_full asserts when usedw >= AFULL_THRESH (legal 1..DEPTH)
AEMPTY_THRESH, 1, rd_almost_empty asserts when usedw <= AEMPTY_THRESH (legal 0..DEPTH-1)
SHOWAHEAD, 0, 0 = normal registered read (1-cycle latency); 1 = first-word-fall-through

Ports:
clk  input  1  single clock, rising edge
reset_n  input  1  asynchronous active-low reset
sclr  input  1  synchronous clear, active high
data_in  input  DATA_WIDTH  write data
wr_req  input  1  write request
wr_full  output  1  FIFO holds DEPTH words
wr_almost_full  output  1  usedw >= AFULL_THRESH
data_out  output  DATA_WIDTH  read data
rd_req  input  1  read request (read acknowledge in show-ahead mode)
rd_empty  output  1  FIFO holds 0 words
rd_almost_empty  output  1  usedw <= AEMPTY_THRESH
usedw  output  ADDR_WIDTH+1  current word count, 0..DEPTH
overflow  output  1  one-cycle pulse: write requested while full
underflow  output  1  one-cycle pulse: read requested while empty

Behaviour:
- Reset (reset_n = 0, asynchronous, takes effect immediately):
  - write and read pointers = 0, usedw = 0
  - rd_empty = 1, rd_almost_empty = 1, wr_full = 0, wr_almost_full = 0
  - overflow = 0, underflow = 0, data_out = 0
  - memory contents are not reset
  - Reset mid-operation discards all stored words; the first accepted write after release is the first word read.
- sclr = 1 at a clock edge has the same effect as reset, synchronously. It has priority over wr_req/rd_req in that cycle, and no error pulses are generated in that cycle.
- Accept rules, evaluated on flag values before the edge:
  - write accepted iff wr_req && !wr_full
  - read accepted iff rd_req && !rd_empty
  - A write while full is not accepted, even if a read is accepted in the same cycle. This keeps the flag path free of combinational request feedback.
- Accepted write: mem[wr_ptr] <= data_in; wr_ptr increments modulo DEPTH (natural ADDR_WIDTH-bit wrap).
- Accepted read: rd_ptr increments modulo DEPTH.
- usedw update: +1 for write only, -1 for read only, unchanged for both or neither. It never leaves 0..DEPTH.
- Flags are combinational decodes of the registered usedw only:
  - wr_full = (usedw == DEPTH), rd_empty = (usedw == 0)
  - almost flags per the parameter thresholds
  - All flags update on the same edge as usedw.
- Simultaneous write and read when empty: write accepted, read rejected, underflow pulses, usedw becomes 1.
- Simultaneous write and read when full: read accepted, write rejected, overflow pulses, usedw becomes DEPTH-1.
- overflow/underflow are registered. They are high for exactly the cycle after the offending edge and are not sticky.
- SHOWAHEAD = 0 (normal mode):
  - data_out is a register loaded with mem[rd_ptr] on an accepted read. The word is visible the cycle after the rd_req edge.
  - data_out holds its value otherwise, including on rejected reads.
- SHOWAHEAD = 1 (show-ahead mode):
  - data_out = mem[rd_ptr], read combinationally, and is valid whenever rd_empty = 0.
  - An accepted rd_req acknowledges the current word; the next word appears after that edge.
  - data_out is undefined when empty; the bench must not check it then.
- Write-then-read of the same location: a word written at edge N may be read at edge N+1 or later, because rd_empty deasserts after edge N.

Decomposition:
- Shared package fifo_pkg holds:
  - the helper function computing DEPTH from ADDR_WIDTH
  - parameter legality checks for the thresholds
- One sub-module is natural: scfifo_ram, a DEPTH x DATA_WIDTH memory with one synchronous write port and one asynchronous read port. It is shared with dcfifo's memory style.
- The top level contains the pointers, usedw, flags, error pulses and the SHOWAHEAD output mux/register.

Test Plan:
1. Fill to full: defaults; write AA,BB,CC,DD on consecutive cycles.
   - Required: usedw 1,2,3,4; wr_almost_full at usedw = 3; wr_full at 4.
   - Then write EE: overflow pulses one cycle, usedw stays 4, EE is dropped.
2. Drain in normal mode: four reads.
   - Required: data_out = AA,BB,CC,DD, each one cycle after its rd_req edge; rd_almost_empty at usedw = 1; rd_empty at 0.
   - A fifth read pulses underflow and data_out holds DD.
3. Concurrent read/write and wrap: start with usedw = 2; hold wr_req and rd_req for 6 cycles with data 11..16.
   - Required: usedw stays 2 throughout and the output order is continuous across pointer wrap.
   - Also: on empty, assert both for one cycle; required: usedw = 1 and underflow pulses.
4. Show-ahead mode (SHOWAHEAD = 1): write 5A.
   - Required: data_out = 5A with no rd_req the cycle after the write edge.
   - Then assert rd_req for one cycle: rd_empty = 1 after the edge.
5. sclr and reset: with usedw = 3, pulse sclr.
   - Required: usedw = 0, rd_empty = 1, data_out = 0 next cycle.
   - Refill to 2, then drop reset_n mid-cycle: outputs go to reset values immediately.
   - After release, write 77 and read it back: data_out = 77.
6. Threshold parameters: AFULL_THRESH = 2, AEMPTY_THRESH = 0, ADDR_WIDTH = 3.
   - Required: wr_almost_full at usedw = 2; rd_almost_empty only at usedw = 0; wr_full at usedw = 8.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared FIFO helpers: depth derivation and threshold legality checks.
package fifo_pkg;

   // Number of words held by a FIFO with the given address width.
   function automatic int unsigned fifo_depth(input int unsigned addr_width);
      return 32'd1 << addr_width;
   endfunction

   // Almost-full threshold must lie in 1..depth.
   function automatic bit afull_thresh_ok(input int unsigned thresh,
                                          input int unsigned depth);
      return (thresh >= 1) && (thresh <= depth);
   endfunction

   // Almost-empty threshold must lie in 0..depth-1.
   function automatic bit aempty_thresh_ok(input int unsigned thresh,
                                           input int unsigned depth);
      return thresh < depth;
   endfunction

endpackage

// File: rtl/scfifo_ram.sv
// DEPTH x DATA_WIDTH storage: one synchronous write port, one asynchronous read port.
// Contents are deliberately not reset.
module scfifo_ram #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] rdata
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   // Write port: store the word on the rising edge when enabled.
   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   // Read port is combinational so show-ahead can present the head word directly.
   assign rdata = mem[raddr];

endmodule

// File: rtl/scfifo.sv
// Single-clock FIFO with fill level, almost flags, error pulses, synchronous clear
// and selectable show-ahead read mode.
module scfifo
   import fifo_pkg::*;
#(
   parameter int unsigned DATA_WIDTH    = 32,
   parameter int unsigned ADDR_WIDTH    = 2,
   parameter int unsigned AFULL_THRESH  = 3,
   parameter int unsigned AEMPTY_THRESH = 1,
   parameter int unsigned SHOWAHEAD     = 0
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  sclr,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  wr_req,
   output logic                  wr_full,
   output logic                  wr_almost_full,
   output logic [DATA_WIDTH-1:0] data_out,
   input  logic                  rd_req,
   output logic                  rd_empty,
   output logic                  rd_almost_empty,
   output logic [ADDR_WIDTH:0]   usedw,
   output logic                  overflow,
   output logic                  underflow
);

   localparam int unsigned DEPTH = fifo_depth(ADDR_WIDTH);

   localparam logic [ADDR_WIDTH:0]   DepthCnt  = DEPTH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]   AfullCnt  = AFULL_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]   AemptyCnt = AEMPTY_THRESH[ADDR_WIDTH:0];
   localparam logic [ADDR_WIDTH:0]   CntOne    = 1;
   localparam logic [ADDR_WIDTH-1:0] PtrOne    = 1;

   if (!afull_thresh_ok(AFULL_THRESH, DEPTH)) begin : g_bad_afull
      $error("scfifo: AFULL_THRESH out of range 1..DEPTH");
   end
   if (!aempty_thresh_ok(AEMPTY_THRESH, DEPTH)) begin : g_bad_aempty
      $error("scfifo: AEMPTY_THRESH out of range 0..DEPTH-1");
   end

   logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
   logic [ADDR_WIDTH:0]   usedw_q, usedw_d;
   logic                  overflow_q, underflow_q;
   logic [DATA_WIDTH-1:0] dout_q;
   logic [DATA_WIDTH-1:0] rd_data;
   logic                  wr_ok, rd_ok;

   // Flags decode only the registered count; requests never feed back into them.
   assign wr_full         = (usedw_q == DepthCnt);
   assign rd_empty        = (usedw_q == '0);
   assign wr_almost_full  = (usedw_q >= AfullCnt);
   assign rd_almost_empty = (usedw_q <= AemptyCnt);
   assign usedw           = usedw_q;
   assign overflow        = overflow_q;
   assign underflow       = underflow_q;

   // A write while full is refused even if a read frees a slot in the same cycle.
   assign wr_ok = wr_req && !wr_full;
   assign rd_ok = rd_req && !rd_empty;

   scfifo_ram #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk   (clk),
      .we    (wr_ok && !sclr),
      .waddr (wr_ptr_q),
      .wdata (data_in),
      .raddr (rd_ptr_q),
      .rdata (rd_data)
   );

   // Next fill level: +1 write only, -1 read only, else unchanged.
   always_comb begin
      usedw_d = usedw_q;
      unique case ({wr_ok, rd_ok})
         2'b10:   usedw_d = usedw_q + CntOne;
         2'b01:   usedw_d = usedw_q - CntOne;
         default: usedw_d = usedw_q;
      endcase
   end

   // Pointers, count, error pulses and the normal-mode output register.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         usedw_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         dout_q      <= '0;
      end else if (sclr) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         usedw_q     <= '0;
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
         dout_q      <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr_q <= wr_ptr_q + PtrOne;
         end
         if (rd_ok) begin
            rd_ptr_q <= rd_ptr_q + PtrOne;
            dout_q   <= rd_data;
         end
         usedw_q     <= usedw_d;
         overflow_q  <= wr_req && wr_full;
         underflow_q <= rd_req && rd_empty;
      end
   end

   // Show-ahead presents the head word directly; normal mode presents the register.
   assign data_out = (SHOWAHEAD != 0) ? rd_data : dout_q;

endmodule

// File: tb/tb_scfifo.sv
// Self-checking bench for scfifo: default, show-ahead and custom-threshold instances.
module tb_scfifo;

   logic clk = 1'b0;
   logic reset_n;
   always #5 clk = ~clk;

   int compared   = 0;
   int mismatched = 0;

   // Default instance (DEPTH 4, AF 3, AE 1, normal read).
   logic        d_sclr, d_wr, d_rd;
   logic [31:0] d_din, d_dout;
   logic        d_full, d_afull, d_empty, d_aempty, d_ov, d_un;
   logic [2:0]  d_usedw;

   scfifo u_dut (
      .clk             (clk),
      .reset_n         (reset_n),
      .sclr            (d_sclr),
      .data_in         (d_din),
      .wr_req          (d_wr),
      .wr_full         (d_full),
      .wr_almost_full  (d_afull),
      .data_out        (d_dout),
      .rd_req          (d_rd),
      .rd_empty        (d_empty),
      .rd_almost_empty (d_aempty),
      .usedw           (d_usedw),
      .overflow        (d_ov),
      .underflow       (d_un)
   );

   // Show-ahead instance.
   logic        s_sclr, s_wr, s_rd;
   logic [31:0] s_din, s_dout;
   logic        s_full, s_afull, s_empty, s_aempty, s_ov, s_un;
   logic [2:0]  s_usedw;

   scfifo #(.SHOWAHEAD(1)) u_sa (
      .clk             (clk),
      .reset_n         (reset_n),
      .sclr            (s_sclr),
      .data_in         (s_din),
      .wr_req          (s_wr),
      .wr_full         (s_full),
      .wr_almost_full  (s_afull),
      .data_out        (s_dout),
      .rd_req          (s_rd),
      .rd_empty        (s_empty),
      .rd_almost_empty (s_aempty),
      .usedw           (s_usedw),
      .overflow        (s_ov),
      .underflow       (s_un)
   );

   // Threshold instance (DEPTH 8, AF 2, AE 0).
   logic        t_sclr, t_wr, t_rd;
   logic [15:0] t_din, t_dout;
   logic        t_full, t_afull, t_empty, t_aempty, t_ov, t_un;
   logic [3:0]  t_usedw;

   scfifo #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .AFULL_THRESH(2), .AEMPTY_THRESH(0)) u_th (
      .clk             (clk),
      .reset_n         (reset_n),
      .sclr            (t_sclr),
      .data_in         (t_din),
      .wr_req          (t_wr),
      .wr_full         (t_full),
      .wr_almost_full  (t_afull),
      .data_out        (t_dout),
      .rd_req          (t_rd),
      .rd_empty        (t_empty),
      .rd_almost_empty (t_aempty),
      .usedw           (t_usedw),
      .overflow        (t_ov),
      .underflow       (t_un)
   );

   // Reference model for the default instance; q is the scoreboard of stored words.
   logic [31:0] q[$];
   logic [31:0] m_dout;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      compared++;
      assert (obs === exp)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Check all default-instance outputs against the model.
   task automatic chk_dflt(input string tag, input logic ov, input logic un);
      int n;
      n = q.size();
      chk({tag, " usedw"},  64'(d_usedw),  64'(n));
      chk({tag, " full"},   64'(d_full),   64'(n == 4));
      chk({tag, " afull"},  64'(d_afull),  64'(n >= 3));
      chk({tag, " empty"},  64'(d_empty),  64'(n == 0));
      chk({tag, " aempty"}, 64'(d_aempty), 64'(n <= 1));
      chk({tag, " ovf"},    64'(d_ov),     64'(ov));
      chk({tag, " unf"},    64'(d_un),     64'(un));
      chk({tag, " dout"},   64'(d_dout),   64'(m_dout));
   endtask

   // One clock on the default instance with model update and full check.
   task automatic cyc(input string tag, input logic wr, input logic [31:0] din,
                      input logic rd, input logic clr);
      logic wacc, racc, ov, un;
      int   n;
      n    = q.size();
      wacc = wr && (n < 4);
      racc = rd && (n > 0);
      ov   = !clr && wr && (n == 4);
      un   = !clr && rd && (n == 0);
      d_wr = wr; d_din = din; d_rd = rd; d_sclr = clr;
      @(posedge clk);
      #1;
      d_wr = 1'b0; d_rd = 1'b0; d_sclr = 1'b0;
      if (clr) begin
         q.delete();
         m_dout = '0;
      end else begin
         if (racc) m_dout = q.pop_front();
         if (wacc) q.push_back(din);
      end
      chk_dflt(tag, ov, un);
   endtask

   initial begin
      reset_n = 1'b0;
      d_sclr = 0; d_wr = 0; d_rd = 0; d_din = '0;
      s_sclr = 0; s_wr = 0; s_rd = 0; s_din = '0;
      t_sclr = 0; t_wr = 0; t_rd = 0; t_din = '0;
      m_dout = '0;
      #1;
      chk_dflt("reset", 1'b0, 1'b0);
      #2;
      reset_n = 1'b1;
      @(posedge clk);
      #1;

      // 1. Fill to full, then overflow drops EE.
      cyc("fill1", 1, 32'hAA, 0, 0);
      cyc("fill2", 1, 32'hBB, 0, 0);
      cyc("fill3", 1, 32'hCC, 0, 0);
      cyc("fill4", 1, 32'hDD, 0, 0);
      cyc("ovf",   1, 32'hEE, 0, 0);

      // 2. Drain in normal mode; fifth read underflows and holds DD.
      for (int i = 0; i < 4; i++) cyc("drain", 0, '0, 1, 0);
      cyc("unf", 0, '0, 1, 0);
      cyc("idle", 0, '0, 0, 0);

      // 3. Concurrent read/write at level 2 across pointer wrap.
      cyc("pre1", 1, 32'h01, 0, 0);
      cyc("pre2", 1, 32'h02, 0, 0);
      for (int i = 0; i < 6; i++) cyc("rw", 1, 32'h11 + 32'(i), 1, 0);
      cyc("rwd1", 0, '0, 1, 0);
      cyc("rwd2", 0, '0, 1, 0);
      cyc("rw_empty", 1, 32'h99, 1, 0);
      cyc("rw_rd", 0, '0, 1, 0);

      // 5. sclr with three words stored, then mid-cycle async reset.
      cyc("sc1", 1, 32'h31, 0, 0);
      cyc("sc2", 1, 32'h32, 0, 0);
      cyc("sc3", 1, 32'h33, 1, 0);
      cyc("sc4", 1, 32'h34, 0, 0);
      cyc("sclr", 1, 32'h35, 1, 1);
      cyc("rf1", 1, 32'h41, 0, 0);
      cyc("rf2", 1, 32'h42, 0, 0);
      cyc("rf_rd", 0, '0, 1, 0);
      cyc("rf3", 1, 32'h43, 0, 0);
      #2;
      reset_n = 1'b0;
      #1;
      q.delete();
      m_dout = '0;
      chk_dflt("async_rst", 1'b0, 1'b0);
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
      cyc("post_wr", 1, 32'h77, 0, 0);
      cyc("post_rd", 0, '0, 1, 0);
      chk("post_77", 64'(d_dout), 64'h77);

      // 4. Show-ahead: head word visible without rd_req; ack advances.
      s_wr = 1; s_din = 32'h5A;
      @(posedge clk); #1;
      s_din = 32'h6B;
      @(posedge clk); #1;
      s_wr = 0;
      chk("sa_head", 64'(s_dout), 64'h5A);
      chk("sa_nempty", 64'(s_empty), 64'd0);
      s_rd = 1;
      @(posedge clk); #1;
      s_rd = 0;
      chk("sa_next", 64'(s_dout), 64'h6B);
      chk("sa_usedw1", 64'(s_usedw), 64'd1);
      s_rd = 1;
      @(posedge clk); #1;
      s_rd = 0;
      chk("sa_empty", 64'(s_empty), 64'd1);
      chk("sa_usedw0", 64'(s_usedw), 64'd0);

      // 6. Custom thresholds on an 8-deep FIFO.
      chk("th_ae0", 64'(t_aempty), 64'd1);
      for (int n = 1; n <= 8; n++) begin
         t_wr = 1; t_din = 16'(n);
         @(posedge clk); #1;
         t_wr = 0;
         chk("th_usedw", 64'(t_usedw), 64'(n));
         chk("th_afull", 64'(t_afull), 64'(n >= 2));
         chk("th_aempty", 64'(t_aempty), 64'd0);
         chk("th_full", 64'(t_full), 64'(n == 8));
      end
      for (int n = 7; n >= 0; n--) begin
         t_rd = 1;
         @(posedge clk); #1;
         t_rd = 0;
         chk("th_rd_data", 64'(t_dout), 64'(8 - n));
         chk("th_rd_afull", 64'(t_afull), 64'(n >= 2));
         chk("th_rd_aempty", 64'(t_aempty), 64'(n == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
